// File: rtl/digit_serial_adder_if.sv
// Operand/result bundle for digit_serial_adder: the requester drives the master side,
// the adder sits on the slave side.
interface digit_serial_adder_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: N-bit add in N/K cycles, K bits per clock, LSB digit first.
// Define DIGIT_SERIAL_ADDER_SUB_EN to make the captured sub bit select a - b.
module digit_serial_adder #(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  digit_serial_adder_if.slave bus
);
  localparam int KS = (K < 1) ? 1 : K;
  localparam int M  = N / KS;
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((K < 1) || (K > N) || ((N % KS) != 0)) begin : g_bad_cfg
      $error("digit_serial_adder: K must satisfy 1 <= K <= N and divide N");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [N-1:0]    a_q, b_q, acc_q, acc_d;
  logic [N-1:0]    b_eff;
  logic            cin_eff;
  logic            accept;
  logic            last;
  logic [BW-1:0]   base;
  logic [K:0]      dig;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  // Subtraction folds into the add path: invert b at capture and force the initial carry.
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  assign accept = (state_q != RUN) && bus.start;
  assign last   = (cnt_q == CW'(M - 1));
  assign base   = BW'(int'(cnt_q) * K);
  assign dig    = {1'b0, a_q[base +: K]} + {1'b0, b_q[base +: K]} + {{K{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    acc_d   = acc_q;
    acc_d[base +: K] = dig[K-1:0];
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = '0;
          carry_d = cin_eff;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d = dig[K];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = dig[K];
          // Carry into the MSB is recovered as a^b^s at bit N-1.
          ovf_d   = a_q[N-1] ^ b_q[N-1] ^ acc_d[N-1] ^ dig[K];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand and partial-sum storage carry no reset; every digit is rewritten before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.a;
      b_q <= b_eff;
    end
    if (state_q == RUN) begin
      acc_q <= acc_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: K=2 main instance plus K=8 and K=1 instances.
module tb_digit_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] last_s;
  logic       last_c, last_v;

  always #5 clk = ~clk;

  digit_serial_adder_if #(.N(8)) if2 ();
  digit_serial_adder_if #(.N(8)) if8 ();
  digit_serial_adder_if #(.N(8)) if1 ();

  digit_serial_adder #(.N(8), .K(2)) u_k2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  digit_serial_adder #(.N(8), .K(8)) u_k8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  digit_serial_adder #(.N(8), .K(1)) u_k1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a falling edge; start is accepted on the next rising edge.
  task automatic run2(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic sub,
                      input logic [7:0] es, input logic ec, input logic ev);
    if2.start = 1'b1; if2.a = a; if2.b = b; if2.cin = cin; if2.sub = sub;
    @(posedge clk);
    @(negedge clk);
    if2.start = 1'b0; if2.a = ~a; if2.b = ~b; if2.cin = ~cin; if2.sub = ~sub;
    chk({tag, " busy0"}, if2.busy, 1'b1);
    chk({tag, " hold0"}, if2.sum, last_s);
    for (int i = 1; i <= 4; i++) begin
      if (i == 1) if2.start = 1'b1;
      if (i == 3) if2.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (i < 4) begin
        chk($sformatf("%s busy%0d", tag, i), {if2.busy, if2.done}, 2'b10);
        chk($sformatf("%s hold%0d", tag, i), if2.sum, last_s);
      end else begin
        chk({tag, " done"}, {if2.busy, if2.done}, 2'b01);
        chk({tag, " sum"}, if2.sum, es);
        chk({tag, " cout"}, if2.cout, ec);
        chk({tag, " ovf"}, if2.ovf, ev);
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, " idle"}, {if2.busy, if2.done}, 2'b00);
    last_s = es; last_c = ec; last_v = ev;
  endtask

  logic [7:0] ba [3];
  logic [7:0] bb [3];
  logic       bc [3];
  logic [7:0] bs [3];
  logic       bco[3];
  logic       bv [3];

  initial begin
    ba = '{8'h12, 8'h40, 8'hC0};
    bb = '{8'h34, 8'h40, 8'h50};
    bc = '{1'b0, 1'b0, 1'b1};
    bs = '{8'h46, 8'h80, 8'h11};
    bco = '{1'b0, 1'b0, 1'b1};
    bv = '{1'b0, 1'b1, 1'b0};

    {if2.start, if2.a, if2.b, if2.cin, if2.sub} = '0;
    {if8.start, if8.a, if8.b, if8.cin, if8.sub} = '0;
    {if1.start, if1.a, if1.b, if1.cin, if1.sub} = '0;
    last_s = 8'h00; last_c = 1'b0; last_v = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outs", {if2.busy, if2.done, if2.sum, if2.cout, if2.ovf}, 12'h000);
    chk("reset k8k1", {if8.done, if1.done, if8.busy, if1.busy}, 4'h0);
    rst_n = 1'b1;

    run2("add0f01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    run2("addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run2("add7f01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run2("add8080c", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    run2("sub0507", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    run2("sub0507c", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
`else
    run2("sub0507", 8'h05, 8'h07, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0);
    run2("sub0507c", 8'h05, 8'h07, 1'b1, 1'b1, 8'h0D, 1'b0, 1'b0);
`endif

    // Start held high: each op accepted on the edge right after its done cycle.
    if2.start = 1'b1; if2.a = ba[0]; if2.b = bb[0]; if2.cin = bc[0]; if2.sub = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk);
        chk($sformatf("b2b%0d run%0d", k, i), {if2.busy, if2.done}, 2'b10);
        chk($sformatf("b2b%0d hold%0d", k, i), if2.sum, last_s);
        if2.a = 8'($urandom); if2.b = 8'($urandom); if2.cin = 1'($urandom);
        @(posedge clk);
      end
      @(negedge clk);
      chk($sformatf("b2b%0d done", k), {if2.busy, if2.done}, 2'b01);
      chk($sformatf("b2b%0d res", k), {if2.sum, if2.cout, if2.ovf}, {bs[k], bco[k], bv[k]});
      last_s = bs[k];
      if (k < 2) begin
        if2.a = ba[k+1]; if2.b = bb[k+1]; if2.cin = bc[k+1];
      end
    end
    if2.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("b2b idle", {if2.busy, if2.done}, 2'b00);

    // Reset asserted during the second RUN cycle.
    if2.start = 1'b1; if2.a = 8'h33; if2.b = 8'h11; if2.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if2.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst busy/done", {if2.busy, if2.done}, 2'b00);
    chk("rst result", {if2.sum, if2.cout, if2.ovf}, 10'h000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rst nodone%0d", i), if2.done, 1'b0);
    end
    rst_n = 1'b1;
    last_s = 8'h00;
    run2("postrst", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);

    // K=8 finishes one edge after accept, K=1 eight edges after.
    if8.start = 1'b1; if8.a = 8'hA5; if8.b = 8'h5A; if8.cin = 1'b1;
    if1.start = 1'b1; if1.a = 8'hA5; if1.b = 8'h5A; if1.cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0;
    if1.start = 1'b0; if1.a = 8'h00; if1.b = 8'h00; if1.cin = 1'b0;
    chk("k8 busy", if8.busy, 1'b1);
    chk("k1 busy", if1.busy, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("k8 done@%0d", i), if8.done, (i == 1));
      chk($sformatf("k1 done@%0d", i), if1.done, (i == 8));
      if (i == 1) chk("k8 res", {if8.sum, if8.cout, if8.ovf}, {8'h00, 1'b1, 1'b0});
      if (i == 8) chk("k1 res", {if1.sum, if1.cout, if1.ovf}, {8'h00, 1'b1, 1'b0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand and result width in bits.
REQ-002 SHALL have parameter K, default 2, meaning digit width in bits added per clock.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin one addition; sampled only when accepted (REQ-012).
REQ-006 SHALL have port a  input  N  first operand, unsigned or two's complement.
REQ-007 SHALL have port b  input  N  second operand.
REQ-008 SHALL have port cin  input  1  carry into bit 0 for add operations.
REQ-009 SHALL have port sub  input  1  1 selects a-b; present in every build, behaviour per REQ-027/028.
REQ-010 SHALL have ports busy  output  1, done  output  1, sum  output  N, cout  output  1, ovf  output  1: busy while computing, one-cycle completion pulse, registered result, carry out of bit N-1, signed overflow.

Function
REQ-011 SHALL contain an FSM with states IDLE, RUN and DONE; M = N/K digits per operation.
REQ-012 SHALL accept start only in IDLE or DONE; on the accepting edge it captures a, b, cin, sub, clears the digit counter and enters RUN.
REQ-013 SHALL, in RUN, add one K-bit digit per cycle, LSB digit first, carrying a one-bit carry register between digits.
REQ-014 SHALL, on the edge that processes digit M-1, load sum, cout and ovf from the completed result and enter DONE.
REQ-015 SHALL assert done for exactly the one cycle spent in DONE, i.e. M edges after the edge that accepted start.
REQ-016 SHALL leave DONE for IDLE after one cycle unless start is high in DONE; if so, back-to-back accept into RUN.
REQ-017 SHALL drive busy high exactly while in RUN.
REQ-018 SHALL ignore start and all operand inputs while in RUN; operand changes after acceptance do not affect the result.
REQ-019 SHALL hold sum, cout and ovf stable from completion until the next completion; they do not change during RUN.
REQ-020 SHALL compute ovf as carry into bit N-1 XOR carry out of bit N-1.
REQ-021 SHALL produce sum equal to (a + b + cin) mod 2^N and cout equal to bit N of that sum for add operations.
REQ-022 SHALL support K = N (M = 1, single-cycle RUN) and K = 1 (bit-serial).
REQ-023 SHALL raise an elaboration error when N mod K is not 0, K < 1 or K > N.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state IDLE, digit counter 0, carry register 0, busy 0, done 0, sum 0, cout 0, ovf 0.
REQ-025 SHALL abandon any in-flight operation on reset with no done pulse and no result update.
REQ-026 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with macro DIGIT_SERIAL_ADDER_SUB_EN defined, compute a + ~b + 1 when captured sub is 1 (cin ignored), with cout = 1 meaning no borrow and ovf per REQ-020.
REQ-028 SHALL, without DIGIT_SERIAL_ADDER_SUB_EN, ignore sub entirely and always perform a + b + cin.

Verification (N=8, K=2, M=4 unless stated)
REQ-029 SHALL cover a=0x0F, b=0x01, cin=0, start one cycle -> busy 4 cycles, done pulse 4 edges after accept, sum=0x10, cout=0, ovf=0.
REQ-030 SHALL cover a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
REQ-031 SHALL cover sub=1, a=0x05, b=0x07 -> with SUB_EN sum=0xFE, cout=0, ovf=0; without SUB_EN sum=0x0C, cout=0.
REQ-032 SHALL cover start held high continuously with changing operands -> operations back-to-back every 5 cycles, each result matching operands captured at its accept edge, start pulses during RUN ignored.
REQ-033 SHALL cover rst_n pulsed low in the second RUN cycle -> busy, done, sum, cout, ovf immediately 0, no done pulse, next start computes correctly.
REQ-034 SHALL cover N=8, K=8 and N=8, K=1 with a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1, done 1 and 8 edges after accept respectively.
